// File: rtl/pkt_router.sv
// pkt_router: routes valid/ready flits to NUM_DST per-port FIFOs by header addr.
// Ports: clk, reset (async active-low), pkt_in/src_valid/src_ready in,
//   dst_valid/dst_ready/dst_type/dst_payload/dst_eop per port, err_drop pulse.
// Option: PKT_ROUTER_STATS_EN adds pkt_count (16-bit saturating eop pops/port).
module pkt_router #(
  parameter int NUM_DST    = 4,
  parameter int ADDR_W     = 2,
  parameter int TYPE_W     = 2,
  parameter int PAYLOAD_W  = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int PKT_W = ADDR_W + TYPE_W + PAYLOAD_W + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PKT_W-1:0]              pkt_in,
  input  logic                          src_valid,
  output logic                          src_ready,
  output logic [NUM_DST-1:0]            dst_valid,
  input  logic [NUM_DST-1:0]            dst_ready,
  output logic [NUM_DST*TYPE_W-1:0]     dst_type,
  output logic [NUM_DST*PAYLOAD_W-1:0]  dst_payload,
  output logic [NUM_DST-1:0]            dst_eop,
  output logic                          err_drop
`ifdef PKT_ROUTER_STATS_EN
  ,
  output logic [NUM_DST*16-1:0]         pkt_count
`endif
);

  localparam int ENT_W = TYPE_W + PAYLOAD_W + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t state;
  logic [ADDR_W-1:0] lock_port;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] cur_port;
  logic [ENT_W-1:0]  entry;
  logic legal;
  logic eop;
  logic xfer;
  logic sel_full;
  logic [NUM_DST-1:0] full;
  logic [NUM_DST-1:0] push;
  logic [NUM_DST-1:0] pop;

  assign addr     = pkt_in[PKT_W-1 -: ADDR_W];
  assign entry    = pkt_in[ENT_W-1:0];
  assign eop      = pkt_in[0];
  assign legal    = 32'(addr) < NUM_DST;
  assign cur_port = (state == ROUTE) ? lock_port : addr;
  assign xfer     = src_valid && src_ready;

  // Loop compare avoids indexing a NUM_DST array with a wider address.
  always_comb begin
    sel_full = 1'b0;
    for (int k = 0; k < NUM_DST; k++)
      if (cur_port == ADDR_W'(k))
        sel_full = full[k];
  end

  always_comb begin
    src_ready = 1'b0;
    if (reset) begin
      unique case (state)
        IDLE:    src_ready = !legal || !sel_full;
        ROUTE:   src_ready = !sel_full;
        default: src_ready = 1'b1;
      endcase
    end
  end

  always_comb begin
    push = '0;
    for (int k = 0; k < NUM_DST; k++)
      push[k] = xfer
             && (cur_port == ADDR_W'(k))
             && (state == ROUTE
                 || (state == IDLE && legal));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lock_port <= '0;
      err_drop  <= 1'b0;
    end else begin
      err_drop <= xfer && state == IDLE && !legal;
      if (xfer) begin
        unique case (state)
          IDLE: begin
            if (!eop) begin
              state     <= legal ? ROUTE : DROP;
              lock_port <= legal ? addr : lock_port;
            end
          end
          ROUTE, DROP: begin
            if (eop) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  for (genvar k = 0; k < NUM_DST; k++) begin : g_fifo
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [ENT_W-1:0] head;

    assign full[k]      = count == CNT_W'(FIFO_DEPTH);
    assign dst_valid[k] = count != '0;
    assign pop[k]       = dst_valid[k] && dst_ready[k];
    // Masked so idle ports (and reset) present zeros.
    assign head = dst_valid[k] ? mem[rd_ptr] : '0;

    assign dst_type[k*TYPE_W +: TYPE_W] =
      head[ENT_W-1 -: TYPE_W];
    assign dst_payload[k*PAYLOAD_W +: PAYLOAD_W] =
      head[PAYLOAD_W:1];
    assign dst_eop[k] = head[0];

    always_ff @(posedge clk) begin
      if (push[k]) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[k]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[k])  rd_ptr <= rd_ptr + 1'b1;
        unique case ({push[k], pop[k]})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end

`ifdef PKT_ROUTER_STATS_EN
    logic [15:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)
        cnt <= '0;
      else if (pop[k] && head[0] && cnt != 16'hFFFF)
        cnt <= cnt + 16'd1;
    end

    assign pkt_count[k*16 +: 16] = cnt;
`endif
  end

endmodule

// File: tb/tb_pkt_router.sv
// tb_pkt_router: random + directed traffic on a 4-port and a 3-port router,
// checked cycle by cycle against a queue-based reference model.
module tb_pkt_router;

  localparam int DEPTH = 4;

  typedef logic [10:0] ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sv;
  logic [12:0] pkt;
  logic [3:0]  dr;
  logic        use3;

  logic        sr4, err4, sr3, err3;
  logic [3:0]  dv4, de4;
  logic [7:0]  dt4;
  logic [31:0] dp4;
  logic [2:0]  dv3, de3;
  logic [5:0]  dt3;
  logic [23:0] dp3;

  logic        m_sr, m_err;
  logic [3:0]  m_dv, m_de;
  logic [7:0]  m_dt;
  logic [31:0] m_dp;

`ifdef PKT_ROUTER_STATS_EN
  logic [63:0] pc4;
  logic [47:0] pc3;
  logic [63:0] m_pc;
  assign m_pc = use3 ? {16'h0, pc3} : pc4;
`endif

  always #5 clk = ~clk;

  pkt_router u_dut4 (
    .clk(clk), .reset(rst_n), .pkt_in(pkt),
    .src_valid(sv & ~use3), .src_ready(sr4),
    .dst_valid(dv4), .dst_ready(dr),
    .dst_type(dt4), .dst_payload(dp4),
    .dst_eop(de4), .err_drop(err4)
`ifdef PKT_ROUTER_STATS_EN
    , .pkt_count(pc4)
`endif
  );

  pkt_router #(.NUM_DST(3)) u_dut3 (
    .clk(clk), .reset(rst_n), .pkt_in(pkt),
    .src_valid(sv & use3), .src_ready(sr3),
    .dst_valid(dv3), .dst_ready(dr[2:0]),
    .dst_type(dt3), .dst_payload(dp3),
    .dst_eop(de3), .err_drop(err3)
`ifdef PKT_ROUTER_STATS_EN
    , .pkt_count(pc3)
`endif
  );

  always_comb begin
    if (use3) begin
      m_sr = sr3; m_err = err3;
      m_dv = {1'b0, dv3}; m_de = {1'b0, de3};
      m_dt = {2'b0, dt3}; m_dp = {8'h0, dp3};
    end else begin
      m_sr = sr4; m_err = err4;
      m_dv = dv4; m_de = de4;
      m_dt = dt4; m_dp = dp4;
    end
  end

  // Reference model: one queue per port plus packet mode
  // (0 waiting header, 1 forwarding to lock, 2 discarding).
  ent_t        q [4][$];
  int          mode, lock, nd;
  logic        exp_err;
  int unsigned stat [4];
  int          n_chk, n_fail;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      stat[k] = 0;
    end
    mode = 0; lock = 0; exp_err = 1'b0;
  endtask

  task automatic cyc(input logic v, input logic [12:0] p,
                     input logic [3:0] r, output logic acc);
    int a, tgt;
    logic legal, esr, nerr;
    ent_t h;
    @(negedge clk);
    sv = v; pkt = p; dr = r;
    #1;
    a = int'(p[12:11]);
    legal = a < nd;
    tgt = (mode == 1) ? lock : a;
    if (mode == 2 || (mode == 0 && !legal)) esr = 1'b1;
    else esr = q[tgt].size() < DEPTH;
    check("src_ready", m_sr, esr);
    check("err_drop", m_err, exp_err);
    for (int k = 0; k < nd; k++) begin
      check($sformatf("dst_valid[%0d]", k), m_dv[k],
            q[k].size() != 0);
      if (q[k].size() != 0) begin
        h = q[k][0];
        check($sformatf("type[%0d]", k), m_dt[k*2 +: 2], h[10:9]);
        check($sformatf("payload[%0d]", k), m_dp[k*8 +: 8], h[8:1]);
        check($sformatf("eop[%0d]", k), m_de[k], h[0]);
        if (r[k]) begin
          void'(q[k].pop_front());
          if (h[0]) stat[k]++;
        end
      end
    end
    nerr = 1'b0;
    acc = v && esr;
    if (acc) begin
      case (mode)
        0: begin
          if (legal) begin
            q[a].push_back(p[10:0]);
            if (!p[0]) begin mode = 1; lock = a; end
          end else begin
            nerr = 1'b1;
            if (!p[0]) mode = 2;
          end
        end
        1: begin
          q[lock].push_back(p[10:0]);
          if (p[0]) mode = 0;
        end
        default: if (p[0]) mode = 0;
      endcase
    end
    exp_err = nerr;
  endtask

  task automatic send(input logic [12:0] p, input logic [3:0] r);
    logic acc;
    int n;
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin
      cyc(1'b1, p, r, acc);
      n++;
    end
    if (!acc) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: flit 0x%0h not accepted", p);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < 4; k++) s += q[k].size();
    return s;
  endfunction

  task automatic drain();
    logic acc;
    int n = 0;
    while (pending() != 0 && n < 100) begin
      cyc(1'b0, 13'h0, 4'hF, acc);
      n++;
    end
    if (pending() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: %0d flits left", pending());
    end
    cyc(1'b0, 13'h0, 4'hF, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    sv = 1'b1; pkt = 13'($urandom); dr = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    check("rst_dst_valid", m_dv, 0);
    check("rst_dst_eop", m_de, 0);
    check("rst_dst_type", m_dt, 0);
    check("rst_dst_payload", m_dp, 0);
    check("rst_err_drop", m_err, 0);
    check("rst_src_ready", m_sr, 0);
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_src_ready_hold", m_sr, 0);
    check("rst_dst_valid_hold", m_dv, 0);
    rst_n = 1'b1;
    sv = 1'b0;
  endtask

  task automatic rand_run(input int ncyc, input int amax);
    logic [12:0] cur;
    logic acc, v, need;
    logic [3:0] r;
    int left;
    left = 0; need = 1'b1; cur = '0;
    for (int i = 0; i < ncyc; i++) begin
      if (need) begin
        if (left == 0) begin
          left = $urandom_range(1, 3);
          cur[12:11] = 2'($urandom_range(0, amax));
        end else begin
          cur[12:11] = 2'($urandom);
        end
        cur[10:1] = 10'($urandom);
        cur[0] = (left == 1);
        need = 1'b0;
      end
      v = ($urandom % 5) != 0;
      r = 4'($urandom) | 4'($urandom);
      cyc(v, cur, r, acc);
      if (acc) begin
        left--;
        need = 1'b1;
      end
    end
  endtask

  task automatic check_stats();
`ifdef PKT_ROUTER_STATS_EN
    for (int k = 0; k < nd; k++)
      check($sformatf("pkt_count[%0d]", k),
            m_pc[k*16 +: 16], stat[k]);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; sv = 1'b0; pkt = '0; dr = '0;
    use3 = 1'b0; nd = 4;
    model_clear();
    do_reset();

    send({2'd0, 2'd1, 8'hA5, 1'b1}, 4'hF);
    send({2'd1, 2'd2, 8'h3C, 1'b1}, 4'hF);
    send({2'd2, 2'd3, 8'hFF, 1'b1}, 4'hF);
    send({2'd3, 2'd0, 8'h00, 1'b1}, 4'hF);
    drain();

    send({2'd2, 2'd1, 8'h11, 1'b0}, 4'hF);
    send({2'd0, 2'd1, 8'h22, 1'b0}, 4'hF);
    send({2'd0, 2'd1, 8'h33, 1'b1}, 4'hF);
    drain();

    for (int i = 0; i < 4; i++)
      send({2'd1, 2'd2, 8'(8'h60 + i), 1'b1}, 4'b1101);
    begin
      logic acc;
      repeat (3) cyc(1'b1, {2'd1, 2'd2, 8'h64, 1'b1}, 4'b1101, acc);
    end
    send({2'd1, 2'd2, 8'h64, 1'b1}, 4'hF);
    send({2'd1, 2'd2, 8'h65, 1'b1}, 4'hF);
    drain();
    check_stats();

    rand_run(400, 3);
    drain();
    check_stats();

    do_reset();
    for (int i = 0; i < 5; i++) begin
      send({2'd2, 2'd1, 8'(i), 1'b0}, 4'hF);
      send({2'd1, 2'd1, 8'(i + 8'h80), 1'b1}, 4'hF);
    end
    drain();
    check_stats();

    send({2'd0, 2'd2, 8'h5A, 1'b0}, 4'h0);
    send({2'd1, 2'd2, 8'h5B, 1'b0}, 4'h0);
    do_reset();
    send({2'd3, 2'd3, 8'hC3, 1'b1}, 4'hF);
    drain();

    use3 = 1'b1; nd = 3;
    do_reset();
    send({2'd3, 2'd1, 8'h44, 1'b0}, 4'hF);
    send({2'd0, 2'd1, 8'h45, 1'b0}, 4'hF);
    send({2'd1, 2'd1, 8'h46, 1'b1}, 4'hF);
    drain();
    rand_run(400, 3);
    drain();
    check_stats();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pkt_router.md
# pkt_router

Parametrised packet router following the single-port packet generator/router. It accepts flits from one source over a valid/ready handshake and routes each packet to one of `NUM_DST` destination ports. The header flit's address field selects the port. The route stays locked until the end-of-packet flit, so multi-flit packets are never interleaved. Each destination has its own FIFO, so a stalled destination does not block traffic already queued for other ports.

## Interface
Parameters:
- `NUM_DST`, 4: number of destination ports (2..8).
- `ADDR_W`, 2: width of the address field; must satisfy 2^`ADDR_W` >= `NUM_DST`.
- `TYPE_W`, 2: width of the packet-type field.
- `PAYLOAD_W`, 8: width of the payload field.
- `FIFO_DEPTH`, 4: entries per destination FIFO; power of two, at least 2.
- Derived `PKT_W` = `ADDR_W`+`TYPE_W`+`PAYLOAD_W`+1. Flit layout: `[PKT_W-1 -: ADDR_W]` = address, next `TYPE_W` bits = type, `[PAYLOAD_W:1]` = payload, `[0]` = eop. Defaults give 13 bits.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pkt_in`  in  `PKT_W`  input flit.
- `src_valid`  in  1  `pkt_in` is valid.
- `src_ready`  out  1  router can accept the flit this cycle.
- `dst_valid`  out  `NUM_DST`  bit k: FIFO k has a flit at its head.
- `dst_ready`  in  `NUM_DST`  bit k: consumer k takes the head flit.
- `dst_type`  out  `NUM_DST*TYPE_W`  head type per port; slice k = `[k*TYPE_W +: TYPE_W]`.
- `dst_payload`  out  `NUM_DST*PAYLOAD_W`  head payload per port, sliced the same way.
- `dst_eop`  out  `NUM_DST`  head eop per port.
- `err_drop`  out  1  one-cycle pulse when a header flit with an address >= `NUM_DST` is accepted.

## Operation
- A flit transfers when `src_valid` && `src_ready`. A transfer when `dst_valid[k]` && `dst_ready[k]` pops FIFO k.
- Route FSM states:
  - `IDLE`, waiting for a header flit. The target port is `pkt_in` address.
  - `ROUTE`, locked to `lock_port`. Later flits go to `lock_port`; their address bits are ignored.
  - `DROP`, discarding the rest of an illegal packet.
- Transitions:
  - `IDLE`, legal header accepted with eop=0: go to `ROUTE` and latch `lock_port`.
  - `IDLE`, legal header accepted with eop=1: push and stay in `IDLE` (single-flit packet).
  - `IDLE`, illegal header (address >= `NUM_DST`) accepted: pulse `err_drop` and push nothing. Go to `DROP` if eop=0, otherwise stay in `IDLE`.
  - `ROUTE`, eop flit accepted: go to `IDLE`.
  - `DROP`, eop flit accepted: go to `IDLE`.
- `src_ready`:
  - `IDLE`: the inverse of FIFO[target] full, or 1 for an illegal address.
  - `ROUTE`: the inverse of FIFO[`lock_port`] full.
  - `DROP`: 1.
  - Always 0 while `reset` is asserted.
- A full FIFO does not accept a push, even if it is popped in the same cycle; `src_ready` never depends on `dst_ready`.
- On a push and pop of the same FIFO in one cycle, the occupancy is unchanged. Pointers wrap modulo `FIFO_DEPTH`. An occupancy counter of width $clog2(`FIFO_DEPTH`)+1 distinguishes full from empty.
- FIFO k stores {type, payload, eop}. Head outputs are valid only while `dst_valid[k]`=1 and hold their value while `dst_ready[k]`=0.
- Reset (asynchronous assert, synchronous release):
  - All FIFOs are emptied, the FSM returns to `IDLE`, and `lock_port`=0.
  - `dst_valid`, `dst_eop`, `dst_type`, `dst_payload` and `err_drop` are 0.
  - Asserting reset in the middle of a packet discards all partial packets.

## Timing
- `src_ready` is combinational from the FSM state, `pkt_in` address and the FIFO full flags.
- Input-to-output latency is 1 cycle: a flit accepted at edge n is visible on `dst_valid[k]` after edge n.
- Throughput is one flit per cycle into and out of each port.
- `err_drop` is registered and asserts for the cycle after the illegal header is accepted.
- Back-pressure: with `dst_ready[k]`=0 held, FIFO k accepts exactly `FIFO_DEPTH` flits. `src_ready` then drops to 0 whenever the target is k.

## Configuration
- `PKT_ROUTER_STATS_EN` defined:
  - Adds output `pkt_count`, `NUM_DST*16` bits.
  - Slice k increments on each popped flit with eop=1 on port k and saturates at 16'hFFFF.
  - Reset value is 0.
- `PKT_ROUTER_STATS_EN` undefined: the `pkt_count` port and its counters do not exist; all other behaviour is identical.

## Test plan
- Reset release with all `dst_ready`=1 and single-flit packets to ports 0, 1, 2, 3 (payloads 8'hA5, 8'h3C, 8'hFF, 8'h00): each appears on its own port one cycle after acceptance, with correct type and eop=1, and `src_ready` stays 1.
- Three-flit packet: header address 2 with eop=0, then two flits with address bits 0, the last with eop=1. All three flits exit port 2 in order and none reach port 0.
- `dst_ready[1]`=0 with 6 flits driven to port 1 at the default depth 4: 4 accepted, `src_ready`=0 on flit 5. After `dst_ready[1]`=1 the remaining 2 are accepted with no loss or duplication.
- `NUM_DST`=3, header address 3 with eop=0 followed by 2 flits, the last with eop=1: `err_drop` pulses once, all 3 flits are consumed, and no `dst_valid` asserts.
- Assert `reset` mid-packet with 2 flits queued on port 0: `dst_valid`=0 immediately and the FSM is in `IDLE`. After release, a header to port 3 routes to port 3.
- With `PKT_ROUTER_STATS_EN` defined, 5 two-flit packets to port 2: `pkt_count` slice 2 = 5 and all other slices = 0.
